// File: rtl/rib_arbiter_yw_pkg.sv
// rib_arbiter_yw_pkg
// Shared types and default constants for the fetch/data bus arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   RibArbMaxStarve  : default consecutive data grants allowed while fetch waits
//   RibArbTimeout    : default BUSY cycles before a timeout abort
//   RibArbErrData    : read data returned on a timeout abort

package rib_arbiter_yw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_EX = 2'd2
    } arb_state_e;

    localparam int          RibArbMaxStarve = 4;
    localparam int          RibArbTimeout   = 255;
    localparam logic [31:0] RibArbErrData   = 32'hDEAD_BEEF;

endpackage

// File: rtl/rib_arbiter_yw.sv
// rib_arbiter_yw
// Shares one downstream bus port between the instruction-fetch port (if_*)
// and the execute-stage data port (ex_*). Grants are zero-latency: a request
// can complete in its own cycle when the bus answers immediately. The data
// port has priority, but after MAX_STARVE consecutive data grants with a
// fetch waiting, the fetch is forced through.
//
// Ports
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   if_req_i/if_addr_i      : fetch request and address
//   if_rdata_o/if_ready_o   : fetched word and single-cycle completion pulse
//   ex_req_i/ex_we_i/...    : load/store request, write enable, address, data
//   ex_rdata_o/ex_ready_o   : load data and single-cycle completion pulse
//   bus_*                   : downstream request side
//   hold_flag_o             : pipeline hold back to the core
//   err_o                   : timeout abort pulse (0 unless the timeout is built in)
//
// Optional feature: define RIB_ARB_TIMEOUT_EN to add a BUSY-state watchdog
// that aborts a stuck transfer after TIMEOUT_CYCLES cycles.
//
// state   | meaning
// IDLE    | no transfer locked; requests arbitrated combinationally
// BUSY_IF | fetch owns the bus, waiting for bus_ready_i
// BUSY_EX | data port owns the bus, waiting for bus_ready_i

module rib_arbiter_yw
    import rib_arbiter_yw_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = RibArbMaxStarve
`ifdef RIB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = RibArbTimeout
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              ex_req_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic [DATA_W-1:0] ex_rdata_o,
    output logic              ex_ready_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ready_i,
    output logic              hold_flag_o,
    output logic              err_o
);

    localparam int              SW         = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0]   STARVE_SAT = SW'(MAX_STARVE);

    arb_state_e        state;
    logic [SW-1:0]     starve_cnt;
    logic              gnt_ex;
    logic              gnt_if;
    logic              owner_ex;
    logic              owner_if;
    logic              done;
    logic              tmo_hit;
    logic [DATA_W-1:0] rdata;

    // Gated by rst_ni so nothing reaches the bus while reset is held.
    assign gnt_ex = rst_ni & ex_req_i & (~if_req_i | (starve_cnt < STARVE_SAT));
    assign gnt_if = rst_ni & if_req_i & ~gnt_ex;

`ifdef RIB_ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Counter is 0 on the first BUSY cycle, so the abort lands on the
    // TIMEOUT_CYCLES-th cycle spent waiting after the grant.
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
    assign rdata   = tmo_hit ? DATA_W'(RibArbErrData) : bus_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rdata   = bus_rdata_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_ex && !bus_ready_i) begin
                        state <= BUSY_EX;
                    end else if (gnt_if && !bus_ready_i) begin
                        state <= BUSY_IF;
                    end
                    if (!if_req_i || gnt_if) begin
                        starve_cnt <= '0;
                    end else if (gnt_ex && (starve_cnt < STARVE_SAT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                BUSY_IF, BUSY_EX: begin
                    if (bus_ready_i || tmo_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        owner_ex = 1'b0;
        owner_if = 1'b0;
        case (state)
            IDLE: begin
                owner_ex = gnt_ex;
                owner_if = gnt_if;
            end
            BUSY_IF: owner_if = 1'b1;
            BUSY_EX: owner_ex = 1'b1;
            default: ;
        endcase
    end

    assign done        = bus_ready_i | tmo_hit;
    assign bus_req_o   = (owner_ex | owner_if) & ~tmo_hit;
    assign bus_we_o    = owner_ex & ex_we_i;
    assign bus_addr_o  = owner_ex ? ex_addr_i  : (owner_if ? if_addr_i : '0);
    assign bus_wdata_o = owner_ex ? ex_wdata_i : '0;

    assign if_ready_o  = owner_if & done;
    assign ex_ready_o  = owner_ex & done;
    assign if_rdata_o  = rdata;
    assign ex_rdata_o  = rdata;
    assign err_o       = tmo_hit;

    // A fetch is only "blocked" when someone else holds the bus.
    assign hold_flag_o = (ex_req_i & ~ex_ready_o) | (if_req_i & ~if_ready_o & ~owner_if);

    ex_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state == BUSY_EX) |-> ex_req_i);
    if_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state == BUSY_IF) |-> if_req_i);

endmodule

// File: tb/tb_rib_arbiter_yw.sv
module tb_rib_arbiter_yw;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        ex_req_i = 1'b0;
    logic        ex_we_i = 1'b0;
    logic [31:0] ex_addr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic [31:0] ex_rdata_o;
    logic        ex_ready_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ready_i = 1'b0;
    logic        hold_flag_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rib_arbiter_yw #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_STARVE(4)
`ifdef RIB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_ready_o(if_ready_o),
        .ex_req_i(ex_req_i),
        .ex_we_i(ex_we_i),
        .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i),
        .ex_rdata_o(ex_rdata_o),
        .ex_ready_o(ex_ready_o),
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ready_i(bus_ready_i),
        .hold_flag_o(hold_flag_o),
        .err_o(err_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i    = 1'b0;
        ex_req_i    = 1'b0;
        ex_we_i     = 1'b0;
        bus_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check_val("rst_bus_req", bus_req_o, 1'b0);
        check_val("rst_if_ready", if_ready_o, 1'b0);
        check_val("rst_ex_ready", ex_ready_o, 1'b0);
        check_val("rst_hold", hold_flag_o, 1'b0);
        check_val("rst_bus_addr", bus_addr_o, 32'h0);
        check_val("rst_err", err_o, 1'b0);
        #9 rst_ni = 1'b1;

        // Fetch only, answered in the grant cycle
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        bus_ready_i = 1'b1; bus_rdata_i = 32'h0000_0013;
        #4;
        check_val("f_bus_req", bus_req_o, 1'b1);
        check_val("f_bus_addr", bus_addr_o, 32'h100);
        check_val("f_bus_we", bus_we_o, 1'b0);
        check_val("f_if_ready", if_ready_o, 1'b1);
        check_val("f_if_rdata", if_rdata_o, 32'h13);
        check_val("f_ex_ready", ex_ready_o, 1'b0);
        check_val("f_hold", hold_flag_o, 1'b0);
        next_cycle();
        idle_inputs();
        #4;
        check_val("f_idle_bus_req", bus_req_o, 1'b0);

        // Contention: load wins, 2-cycle latency, fetch follows
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h104;
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h2000;
        bus_ready_i = 1'b0;
        #4;
        check_val("c0_bus_addr", bus_addr_o, 32'h2000);
        check_val("c0_bus_we", bus_we_o, 1'b0);
        check_val("c0_ex_ready", ex_ready_o, 1'b0);
        check_val("c0_if_ready", if_ready_o, 1'b0);
        check_val("c0_hold", hold_flag_o, 1'b1);
        next_cycle();
        bus_ready_i = 1'b1; bus_rdata_i = 32'h0000_CAFE;
        #4;
        check_val("c1_bus_addr", bus_addr_o, 32'h2000);
        check_val("c1_ex_ready", ex_ready_o, 1'b1);
        check_val("c1_ex_rdata", ex_rdata_o, 32'hCAFE);
        check_val("c1_if_ready", if_ready_o, 1'b0);
        check_val("c1_hold", hold_flag_o, 1'b1);
        next_cycle();
        ex_req_i = 1'b0; bus_rdata_i = 32'h0000_0033;
        #4;
        check_val("c2_bus_addr", bus_addr_o, 32'h104);
        check_val("c2_if_ready", if_ready_o, 1'b1);
        check_val("c2_if_rdata", if_rdata_o, 32'h33);
        check_val("c2_hold", hold_flag_o, 1'b0);
        next_cycle();
        idle_inputs();

        // Starvation guard: 4 data grants then a fetch, repeating
        next_cycle();
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h3000;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        bus_ready_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            #4;
            if ((i % 5) == 4) begin
                check_val($sformatf("s%0d_if_ready", i), if_ready_o, 1'b1);
                check_val($sformatf("s%0d_ex_ready", i), ex_ready_o, 1'b0);
                check_val($sformatf("s%0d_addr", i), bus_addr_o, 32'h200);
            end else begin
                check_val($sformatf("s%0d_if_ready", i), if_ready_o, 1'b0);
                check_val($sformatf("s%0d_ex_ready", i), ex_ready_o, 1'b1);
                check_val($sformatf("s%0d_addr", i), bus_addr_o, 32'h3000);
            end
            check_val($sformatf("s%0d_hold", i), hold_flag_o, 1'b1);
            next_cycle();
        end
        idle_inputs();

        // Lock: store in flight cannot be pre-empted by a fetch
        next_cycle();
        ex_req_i = 1'b1; ex_we_i = 1'b1; ex_addr_i = 32'h4000; ex_wdata_i = 32'h55AA;
        bus_ready_i = 1'b0;
        #4;
        check_val("l0_bus_we", bus_we_o, 1'b1);
        check_val("l0_bus_wdata", bus_wdata_o, 32'h55AA);
        check_val("l0_bus_addr", bus_addr_o, 32'h4000);
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h300;
        for (int i = 1; i < 3; i++) begin
            #4;
            check_val($sformatf("l%0d_bus_addr", i), bus_addr_o, 32'h4000);
            check_val($sformatf("l%0d_if_ready", i), if_ready_o, 1'b0);
            check_val($sformatf("l%0d_ex_ready", i), ex_ready_o, 1'b0);
            check_val($sformatf("l%0d_hold", i), hold_flag_o, 1'b1);
            next_cycle();
        end
        bus_ready_i = 1'b1;
        #4;
        check_val("l3_bus_addr", bus_addr_o, 32'h4000);
        check_val("l3_ex_ready", ex_ready_o, 1'b1);
        check_val("l3_if_ready", if_ready_o, 1'b0);
        check_val("l3_err", err_o, 1'b0);
        next_cycle();
        ex_req_i = 1'b0; ex_we_i = 1'b0;
        #4;
        check_val("l4_bus_addr", bus_addr_o, 32'h300);
        check_val("l4_bus_we", bus_we_o, 1'b0);
        check_val("l4_if_ready", if_ready_o, 1'b1);
        next_cycle();
        idle_inputs();

        // Reset while a load is locked in BUSY_EX
        next_cycle();
        ex_req_i = 1'b1; ex_addr_i = 32'h5000; bus_ready_i = 1'b0;
        next_cycle();
        check_val("r_busy_bus_req", bus_req_o, 1'b1);
        rst_ni = 1'b0; bus_ready_i = 1'b1;
        #1;
        check_val("r_bus_req", bus_req_o, 1'b0);
        check_val("r_ex_ready", ex_ready_o, 1'b0);
        check_val("r_if_ready", if_ready_o, 1'b0);
        ex_req_i = 1'b0; bus_ready_i = 1'b0;
        #2 rst_ni = 1'b1;
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h400; bus_ready_i = 1'b1; bus_rdata_i = 32'h77;
        #4;
        check_val("r_after_if_ready", if_ready_o, 1'b1);
        check_val("r_after_addr", bus_addr_o, 32'h400);
        next_cycle();
        idle_inputs();

`ifdef RIB_ARB_TIMEOUT_EN
        // Timeout abort on a load that never completes
        next_cycle();
        ex_req_i = 1'b1; ex_addr_i = 32'h7000; bus_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #4;
            check_val($sformatf("t%0d_err", i), err_o, 1'b0);
            check_val($sformatf("t%0d_ex_ready", i), ex_ready_o, 1'b0);
            next_cycle();
        end
        #4;
        check_val("t8_err", err_o, 1'b1);
        check_val("t8_ex_ready", ex_ready_o, 1'b1);
        check_val("t8_ex_rdata", ex_rdata_o, 32'hDEAD_BEEF);
        check_val("t8_bus_req", bus_req_o, 1'b0);
        next_cycle();
        ex_req_i = 1'b0;
        #4;
        check_val("t9_err", err_o, 1'b0);
        next_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
